bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Programmable interval timer and 64-bit cycle counter, attached as a slave on the CPU data bus in parallel with the other bus peripherals.
- Decoded by the CPU bus like the other slaves: the bus asserts `en`, the block drives `dataOut` and `nak`.
- Drives one CPU interrupt line, assigned to cpuInterrupt[3].
- Provides periodic OS ticks and a precise cycle timebase.

Parameters:
- PRESC_W, 8: width of the prescaler field and prescaler counter.
- RST_LOAD, 32'h0: reset value of the LOAD register.

Ports:
- clk  in  1  CPU clock; all logic is on its rising edge.
- rst  in  1  Reset. Asynchronous, active-high; the codebase's global reset.
- en  in  1  Slave select from the CPU bus decoder.
- addrBus  in  32  Bus address. Only [4:2] is decoded; all other bits are ignored.
- dataInBus  in  32  Write data.
- weBus  in  4  Byte write enables. weBus==0 with en high is a read.
- dataOut  out  32  Read data, registered.
- nak  out  1  Constant 0; the block never stalls the bus.
- timerInt  out  1  Interrupt request, registered level.

Behaviour:
- Register map, selected by addrBus[4:2]:
  - 0 CTRL: [0] EN, [1] AUTO, [2] IE, [8+PRESC_W-1:8] PRESC. All other bits read 0.
  - 1 LOAD: reload value.
  - 2 COUNT: live counter.
  - 3 STATUS: [0] PEND. Write-1-to-clear.
  - 4 CYC_LO: low 32 bits of the 64-bit cycle counter. A read latches the high 32 bits into SHADOW in the same edge.
  - 5 CYC_HI: reads SHADOW. Writes are ignored.
  - 6, 7: read 0, writes ignored.
- Writes: on a clk edge with en=1 and weBus!=0, each byte lane i with weBus[i]=1 updates bits [8i+7:8i] of the selected register. CYC_LO and CYC_HI are read-only.
- Reads: on a clk edge with en=1 and weBus==0, dataOut <= selected register value (pre-edge value). Latency is 1 cycle. dataOut holds its value at all other times.
- Reset values: CTRL=0, LOAD=RST_LOAD, COUNT=0, PEND=0, cycle counter=0, SHADOW=0, prescaler counter pc=0, dataOut=0, timerInt=0.
- Cycle counter: increments every clk, unconditionally, and wraps at 2^64-1 to 0.
- Prescaler (only while EN=1):
  - pc counts 0..PRESC.
  - When pc==PRESC a tick is generated and pc <= 0.
  - While EN=0, pc is held at 0.
  - A CTRL write that sets EN from 0 to 1 forces pc <= 0.
- On a tick:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0 (expiry): PEND <= 1. Then, if AUTO=1, COUNT <= LOAD; otherwise EN <= 0 and COUNT stays 0.
  - The expiry period in AUTO mode is (LOAD+1)*(PRESC+1) clocks.
- timerInt <= PEND & IE, registered. It changes one cycle after PEND or IE changes.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same edge: the write wins; the decrement and expiry are both lost.
  - Expiry and a STATUS W1C in the same edge: set wins, so PEND stays 1.
  - Bus write to CTRL clearing EN and an expiry in the same edge: the write value applies to CTRL, and the expiry still sets PEND.
  - Writing LOAD never affects COUNT directly.
  - LOAD=0 with AUTO: expiry on every tick.
  - PRESC=0: a tick every clock.
- Reset asserted mid-count: all state returns to its reset value immediately (asynchronous). Counting resumes only after software sets EN again.

Test Plan:
- Reset mid-operation: run with EN=1 and COUNT=5, pulse rst → all registers read back at reset values; dataOut=0; timerInt=0 within the reset cycle.
- One-shot: write LOAD=3, COUNT=3, CTRL=0x5 (EN, IE, PRESC=0) → expiry 4 clocks after the CTRL write; PEND=1; timerInt high 1 cycle later; CTRL reads 0x4 (EN cleared); COUNT=0.
- Auto-reload with prescaler: LOAD=1, COUNT=1, CTRL=0x0207 → PEND set every 6 clocks. W1C STATUS=1 → timerInt drops the next cycle. A W1C landing on an expiry edge leaves PEND=1.
- Byte-lane writes: write 0xAABBCCDD to LOAD with weBus=4'b0101 over LOAD=0 → LOAD reads 0x00BB00DD, with 1-cycle read latency.
- Cycle counter wrap: force the counter to 0x00000000_FFFFFFFE, read CYC_LO twice across the carry → the first read returns 0xFFFFFFFE with CYC_HI=0; a later read after the carry gives CYC_HI=1, consistent with the paired CYC_LO.
- Write-vs-tick collision: write COUNT=9 on the tick edge where COUNT==0 → COUNT reads 9; PEND remains 0.

Source files
------------

// File: rtl/bus_timer.sv
// Programmable interval timer with prescaler plus a free-running 64-bit cycle
// counter, exposed as a byte-writable register slave on the CPU data bus.
module bus_timer #(
  parameter int          PRESC_W  = 8,
  parameter logic [31:0] RST_LOAD = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] addrBus,
  input  logic [31:0] dataInBus,
  input  logic [3:0]  weBus,
  output logic [31:0] dataOut,
  output logic        nak,
  output logic        timerInt
);

  typedef enum logic [2:0] {
    R_CTRL   = 3'd0,
    R_LOAD   = 3'd1,
    R_COUNT  = 3'd2,
    R_STATUS = 3'd3,
    R_CYC_LO = 3'd4,
    R_CYC_HI = 3'd5,
    R_RSV6   = 3'd6,
    R_RSV7   = 3'd7
  } reg_sel_e;

  reg_sel_e           sel;
  logic               rd;
  logic               wr;
  logic               wr_count;
  logic               tick;
  logic               expire;
  logic [31:0]        mask;
  logic [31:0]        ctrl_word;
  logic [31:0]        ctrl_nxt;
  logic [31:0]        count_nxt;
  logic [31:0]        rd_data;

  logic               ctrl_en;
  logic               ctrl_auto;
  logic               ctrl_ie;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pc;
  logic [31:0]        load;
  logic [31:0]        count;
  logic [31:0]        shadow;
  logic               pend;
  logic [63:0]        cyc_cnt;

  logic               unused_ok;

  assign unused_ok = ^{addrBus[31:5], addrBus[1:0], ctrl_nxt};
  assign nak       = 1'b0;

  assign sel      = reg_sel_e'(addrBus[4:2]);
  assign rd       = en && (weBus == 4'b0000);
  assign wr       = en && (weBus != 4'b0000);
  assign mask     = {{8{weBus[3]}}, {8{weBus[2]}}, {8{weBus[1]}}, {8{weBus[0]}}};
  assign tick     = ctrl_en && (pc == presc);
  assign wr_count = wr && (sel == R_COUNT);
  // A COUNT write on a tick edge swallows both the decrement and the expiry.
  assign expire   = tick && (count == 32'd0) && !wr_count;

  // NOTE: every always_comb assigns its outputs a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[0]           = ctrl_en;
    ctrl_word[1]           = ctrl_auto;
    ctrl_word[2]           = ctrl_ie;
    ctrl_word[8 +: PRESC_W] = presc;
  end

  // One-shot expiry drops EN first; a bus write to CTRL then overrides its lanes.
  always_comb begin
    ctrl_nxt = ctrl_word;
    if (expire && !ctrl_auto) begin
      ctrl_nxt[0] = 1'b0;
    end
    if (wr && (sel == R_CTRL)) begin
      ctrl_nxt = (ctrl_nxt & ~mask) | (dataInBus & mask);
    end
  end

  always_comb begin
    count_nxt = count;
    if (wr_count) begin
      count_nxt = (count & ~mask) | (dataInBus & mask);
    end else if (tick) begin
      if (count != 32'd0) begin
        count_nxt = count - 32'd1;
      end else if (ctrl_auto) begin
        count_nxt = load;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      R_CTRL:   rd_data = ctrl_word;
      R_LOAD:   rd_data = load;
      R_COUNT:  rd_data = count;
      R_STATUS: rd_data = {31'd0, pend};
      R_CYC_LO: rd_data = cyc_cnt[31:0];
      R_CYC_HI: rd_data = shadow;
      default:  rd_data = '0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      presc     <= '0;
      pc        <= '0;
      load      <= RST_LOAD;
      count     <= '0;
      pend      <= 1'b0;
      cyc_cnt   <= '0;
      shadow    <= '0;
      dataOut   <= '0;
      timerInt  <= 1'b0;
    end else begin
      ctrl_en   <= ctrl_nxt[0];
      ctrl_auto <= ctrl_nxt[1];
      ctrl_ie   <= ctrl_nxt[2];
      presc     <= ctrl_nxt[8 +: PRESC_W];

      // pc sits at 0 while disabled, so enabling always starts a fresh period.
      if (!ctrl_en || tick) begin
        pc <= '0;
      end else begin
        pc <= pc + 1'b1;
      end

      if (wr && (sel == R_LOAD)) begin
        load <= (load & ~mask) | (dataInBus & mask);
      end
      count <= count_nxt;

      // Expiry beats a simultaneous write-1-to-clear.
      if (expire) begin
        pend <= 1'b1;
      end else if (wr && (sel == R_STATUS) && weBus[0] && dataInBus[0]) begin
        pend <= 1'b0;
      end

      cyc_cnt <= cyc_cnt + 64'd1;
      if (rd && (sel == R_CYC_LO)) begin
        shadow <= cyc_cnt[63:32];
      end

      if (rd) begin
        dataOut <= rd_data;
      end
      timerInt <= pend && ctrl_ie;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Randomized and directed bench for bus_timer: a behavioural model predicts
// each read and the interrupt level; a negedge monitor compares them.
module tb_bus_timer;

  localparam int A_CTRL   = 0;
  localparam int A_LOAD   = 1;
  localparam int A_COUNT  = 2;
  localparam int A_STATUS = 3;
  localparam int A_CYC_LO = 4;
  localparam int A_CYC_HI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] addrBus = '0;
  logic [31:0] dataInBus = '0;
  logic [3:0]  weBus = '0;
  logic [31:0] dataOut;
  logic        nak;
  logic        timerInt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_en, m_auto, m_ie, m_pend;
  logic [7:0]  m_presc;
  int unsigned m_phase;
  logic [31:0] m_load, m_count, m_shadow;
  logic [63:0] m_cyc;

  logic [31:0] exp_q[$];
  logic        tim_q[$];

  bus_timer #(.PRESC_W(8), .RST_LOAD(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .addrBus   (addrBus),
    .dataInBus (dataInBus),
    .weBus     (weBus),
    .dataOut   (dataOut),
    .nak       (nak),
    .timerInt  (timerInt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_presc = 0; m_phase = 0;
    m_load = 0; m_count = 0; m_shadow = 0; m_cyc = 0;
    exp_q.delete();
    tim_q.delete();
  endtask

  // One clock of behaviour: the timer's own effect first, then the bus write
  // takes precedence on whatever register it names.
  task automatic model_step(input logic e, input logic [31:0] a, input logic [3:0] w,
                            input logic [31:0] d);
    int          sel;
    logic        is_rd, is_wr, tick, expired;
    logic [31:0] ctrl, n_count;
    logic        n_en, n_pend;
    sel   = int'(a[4:2]);
    is_rd = e && (w == 4'd0);
    is_wr = e && (w != 4'd0);

    if (is_rd) begin
      case (sel)
        A_CTRL:   exp_q.push_back({16'd0, m_presc, 5'd0, m_ie, m_auto, m_en});
        A_LOAD:   exp_q.push_back(m_load);
        A_COUNT:  exp_q.push_back(m_count);
        A_STATUS: exp_q.push_back({31'd0, m_pend});
        A_CYC_LO: exp_q.push_back(m_cyc[31:0]);
        A_CYC_HI: exp_q.push_back(m_shadow);
        default:  exp_q.push_back(32'd0);
      endcase
    end
    tim_q.push_back(m_pend & m_ie);

    tick    = m_en && (m_phase == int'(m_presc));
    expired = 0;
    n_count = m_count;
    n_en    = m_en;
    n_pend  = m_pend;
    if (tick) begin
      if (m_count != 0) n_count = m_count - 1;
      else begin
        expired = 1;
        if (m_auto) n_count = m_load;
        else n_en = 0;
      end
    end
    if (is_wr && sel == A_COUNT) begin
      n_count = lanes(m_count, d, w);
      expired = 0;
      n_en    = m_en;
    end
    if (is_wr && sel == A_STATUS && w[0] && d[0]) n_pend = 0;
    if (expired) n_pend = 1;

    ctrl = {16'd0, m_presc, 5'd0, m_ie, m_auto, n_en};
    if (is_wr && sel == A_CTRL) ctrl = lanes(ctrl, d, w);
    if (is_wr && sel == A_LOAD) m_load = lanes(m_load, d, w);
    if (is_rd && sel == A_CYC_LO) m_shadow = m_cyc[63:32];

    m_phase = (!m_en || tick) ? 0 : m_phase + 1;
    m_en    = ctrl[0];
    m_auto  = ctrl[1];
    m_ie    = ctrl[2];
    m_presc = ctrl[15:8];
    m_count = n_count;
    m_pend  = n_pend;
    m_cyc   = m_cyc + 1;
  endtask

  task automatic bus_cycle(input logic e, input int sel, input logic [3:0] w,
                           input logic [31:0] d);
    logic [31:0] a;
    a         = $urandom();
    a[4:2]    = 3'(sel);
    en        = e;
    addrBus   = a;
    weBus     = w;
    dataInBus = d;
    @(posedge clk);
    model_step(e, a, w, d);
    @(negedge clk);
    en    = 1'b0;
    weBus = 4'd0;
  endtask

  task automatic wr(input int sel, input logic [31:0] d);
    bus_cycle(1'b1, sel, 4'hF, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 0, 4'd0, 32'd0);
  endtask

  task automatic rd_chk(input int sel, input logic [31:0] exp, input string name);
    bus_cycle(1'b1, sel, 4'd0, 32'd0);
    check(name, dataOut, exp);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_dataOut", dataOut, 32'd0);
    check("rst_timerInt", {31'd0, timerInt}, 32'd0);
    check("nak", {31'd0, nak}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: compares whatever the model predicted for this edge.
  initial begin
    logic [31:0] e_data;
    logic        e_int;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e_data = exp_q.pop_front();
        check("sb_dataOut", dataOut, e_data);
      end
      if (tim_q.size() > 0) begin
        e_int = tim_q.pop_front();
        check("sb_timerInt", {31'd0, timerInt}, {31'd0, e_int});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, sel;
    logic [3:0]  w;
    logic [31:0] d;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation: auto-reload running with PEND and IE set.
    wr(A_LOAD, 32'd5);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    idle(2);
    check("pre_rst_timerInt", {31'd0, timerInt}, 32'd1);
    rd_chk(A_COUNT, 32'd4, "pre_rst_count");
    pulse_reset();
    rd_chk(A_CYC_LO, 32'd0, "rst_cyc_lo");
    rd_chk(A_CYC_HI, 32'd0, "rst_cyc_hi");
    rd_chk(A_CTRL,   32'd0, "rst_ctrl");
    rd_chk(A_LOAD,   32'd0, "rst_load");
    rd_chk(A_COUNT,  32'd0, "rst_count");
    rd_chk(A_STATUS, 32'd0, "rst_status");

    // One-shot, PRESC=0: expiry on the 4th edge after the CTRL write.
    wr(A_LOAD, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h5);
    idle(3);
    rd_chk(A_STATUS, 32'd0, "oneshot_pend_early");
    check("oneshot_int_early", {31'd0, timerInt}, 32'd0);
    rd_chk(A_STATUS, 32'd1, "oneshot_pend");
    check("oneshot_int", {31'd0, timerInt}, 32'd1);
    rd_chk(A_CTRL,  32'h4, "oneshot_ctrl");
    rd_chk(A_COUNT, 32'd0, "oneshot_count");
    wr(A_STATUS, 32'd1);

    // Auto-reload with PRESC=2, LOAD=1: expiry every 6 clocks.
    wr(A_LOAD, 32'd1);
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'h0207);
    idle(5);
    rd_chk(A_STATUS, 32'd0, "auto_pend_early");
    rd_chk(A_STATUS, 32'd1, "auto_pend");
    wr(A_STATUS, 32'd1);
    check("auto_int_hold", {31'd0, timerInt}, 32'd1);
    rd_chk(A_STATUS, 32'd0, "auto_w1c");
    check("auto_int_drop", {31'd0, timerInt}, 32'd0);
    idle(2);
    wr(A_STATUS, 32'd1);
    rd_chk(A_STATUS, 32'd1, "auto_w1c_vs_expiry");
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'd1);

    // Byte-lane write.
    wr(A_LOAD, 32'd0);
    bus_cycle(1'b1, A_LOAD, 4'b0101, 32'hAABBCCDD);
    rd_chk(A_LOAD, 32'h00BB00DD, "byte_lanes");

    // Cycle counter carry into the high word.
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFE;
    m_cyc = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.cyc_cnt;
    rd_chk(A_CYC_LO, 32'hFFFF_FFFE, "cyc_lo_pre");
    rd_chk(A_CYC_HI, 32'd0,         "cyc_hi_pre");
    rd_chk(A_CYC_LO, 32'd0,         "cyc_lo_post");
    rd_chk(A_CYC_HI, 32'd1,         "cyc_hi_post");

    // COUNT write on the tick edge where COUNT==0.
    wr(A_COUNT, 32'd0);
    wr(A_STATUS, 32'd1);
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'd9);
    rd_chk(A_COUNT,  32'd9, "collide_count");
    rd_chk(A_STATUS, 32'd0, "collide_pend");
    wr(A_CTRL, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 7);
      d   = $urandom();
      w   = 4'($urandom_range(1, 15));
      if (r < 40) begin
        bus_cycle(1'b1, sel, 4'd0, 32'd0);
      end else if (r < 55) begin
        bus_cycle(1'b0, sel, w, d);
      end else begin
        if (sel == A_CTRL) d[15:8] = 8'($urandom_range(0, 3));
        if (sel == A_COUNT || sel == A_LOAD) d = 32'($urandom_range(0, 6));
        bus_cycle(1'b1, sel, w, d);
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
